// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
//   Shared definitions for the key event decoder:
//     - state_e      : 3-bit encoding of the click-classification FSM states
//     - us_to_cycles : converts a time in microseconds to a clock-cycle count,
//                      never returning less than one cycle
//     - max_u        : unsigned maximum, used to size the shared timer
// -----------------------------------------------------------------------------
package key_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_GAP = 3'd3,
        ST_PRESS2   = 3'd4
    } state_e;

    // N = us * 1000 / clk_prd_ns, clamped to >= 1. The product is formed in
    // 64 bits so large microsecond values cannot overflow before the divide.
    function automatic int unsigned us_to_cycles(input int unsigned us,
                                                 input int unsigned clk_prd_ns);
        logic [63:0] n;
        n = (64'(us) * 64'd1000) / 64'(clk_prd_ns);
        if (n < 64'd1)
            n = 64'd1;
        return n[31:0];
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_evt_timer.sv
// -----------------------------------------------------------------------------
// key_evt_timer
//   Saturating up-counter with synchronous clear and count enable, plus a
//   flag that is high while the count equals a caller-supplied threshold.
//   Clear has priority over enable. At all-ones the count holds rather than
//   wrapping, so a stale count can never alias back onto a small threshold.
//
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous reset, active high (count -> 0)
//   clr_i   : synchronous clear to 0
//   en_i    : count enable
//   thr_i   : threshold compared against the current count
//   eq_o    : 1 while count == thr_i (combinational from the count register)
// -----------------------------------------------------------------------------
module key_evt_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] thr_i,
    output logic          eq_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != {CW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign eq_o = (cnt_q == thr_i);

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//   Classifies a debounced key into press / release / short-click /
//   long-press / double-click events, with optional auto-repeat while held.
//   All event outputs are registered one-cycle pulses that appear the cycle
//   after the KEY_I edge (or timer threshold) that caused them.
//
//   Optional feature: define KEY_EVENT_REPEAT_EN to enable auto-repeat in
//   HOLD. Without it REPEAT_O is tied low and no repeat logic exists.
//
// Parameters
//   C_CLK_PRD_NS    : clock period, ns
//   C_LONG_PRESS_US : hold time that makes a press long
//   C_DOUBLE_GAP_US : max release-to-press gap for a double click
//   C_REPEAT_US     : auto-repeat period in HOLD
//
// Ports
//   CLK_I     : clock, rising edge
//   RST_I     : asynchronous reset, active high
//   KEY_I     : debounced key level, 1 = pressed, synchronous to CLK_I
//   PRESS_O   : pulse per accepted press
//   RELEASE_O : pulse per accepted release
//   SHORT_O   : pulse for a single short click
//   LONG_O    : pulse when the long threshold is reached
//   DOUBLE_O  : pulse for a double click (same cycle as the 2nd RELEASE_O)
//   REPEAT_O  : auto-repeat pulse while held past the long threshold
//   BUSY_O    : 1 whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int unsigned C_CLK_PRD_NS    = 10,
    parameter int unsigned C_LONG_PRESS_US = 1000000,
    parameter int unsigned C_DOUBLE_GAP_US = 300000,
    parameter int unsigned C_REPEAT_US     = 200000
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic KEY_I,
    output logic PRESS_O,
    output logic RELEASE_O,
    output logic SHORT_O,
    output logic LONG_O,
    output logic DOUBLE_O,
    output logic REPEAT_O,
    output logic BUSY_O
);

    localparam int unsigned N_LONG = us_to_cycles(C_LONG_PRESS_US, C_CLK_PRD_NS);
    localparam int unsigned N_GAP  = us_to_cycles(C_DOUBLE_GAP_US, C_CLK_PRD_NS);
    localparam int unsigned N_REP  = us_to_cycles(C_REPEAT_US,     C_CLK_PRD_NS);
    localparam int unsigned N_MAX  = max_u(max_u(N_LONG, N_GAP), N_REP);
    // One spare bit above the largest threshold so saturation sits well clear
    // of every compare value.
    localparam int unsigned CW     = $clog2(N_MAX) + 1;

    localparam logic [CW-1:0] THR_LONG = CW'(N_LONG - 1);
    localparam logic [CW-1:0] THR_GAP  = CW'(N_GAP  - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CW-1:0] THR_REP  = CW'(N_REP  - 1);
`endif

    state_e        state_q;
    logic          key_d;
    logic          rise;
    logic          fall;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_eq;
    logic [CW-1:0] tmr_thr;

    logic press_q;
    logic rel_q;
    logic short_q;
    logic long_q;
    logic dbl_q;

    assign rise = KEY_I & ~key_d;
    assign fall = ~KEY_I & key_d;

    // One timer is shared by all timed states; the threshold follows the state.
    always_comb begin
        tmr_thr = THR_LONG;
        case (state_q)
            ST_WAIT_GAP: tmr_thr = THR_GAP;
`ifdef KEY_EVENT_REPEAT_EN
            ST_HOLD:     tmr_thr = THR_REP;
`endif
            default:     tmr_thr = THR_LONG;
        endcase
    end

    // Holding the timer cleared throughout IDLE means it starts from 0 on the
    // first PRESS1 cycle. Leaving PRESS1 (either way) clears it again so
    // WAIT_GAP / HOLD also start from 0. In HOLD each repeat re-arms it.
    always_comb begin
        tmr_en  = (state_q == ST_PRESS1) || (state_q == ST_WAIT_GAP);
        tmr_clr = (state_q == ST_IDLE) ||
                  ((state_q == ST_PRESS1) && (fall || tmr_eq));
`ifdef KEY_EVENT_REPEAT_EN
        tmr_en  = tmr_en  || (state_q == ST_HOLD);
        tmr_clr = tmr_clr || ((state_q == ST_HOLD) && tmr_eq);
`endif
    end

    key_evt_timer #(
        .CW (CW)
    ) u_timer (
        .clk_i (CLK_I),
        .rst_i (RST_I),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .thr_i (tmr_thr),
        .eq_o  (tmr_eq)
    );

`ifdef KEY_EVENT_REPEAT_EN
    logic rep_q;
`endif

    // key_d resets to 1: a key already down when reset releases looks like
    // "still pressed", so it must be released and pressed again to count.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            key_d   <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            key_d   <= KEY_I;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            rep_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // A fall here (e.g. key held through reset) is ignored.
                    if (rise) begin
                        press_q <= 1'b1;
                        state_q <= ST_PRESS1;
                    end
                end
                ST_PRESS1: begin
                    // Fall is tested first so a release on the threshold
                    // cycle is still a short click.
                    if (fall) begin
                        rel_q   <= 1'b1;
                        state_q <= ST_WAIT_GAP;
                    end else if (tmr_eq) begin
                        long_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fall) begin
                        rel_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    else if (tmr_eq) begin
                        rep_q <= 1'b1;
                    end
`endif
                end
                ST_WAIT_GAP: begin
                    // Rise is tested first so a press on the expiry cycle
                    // still makes a double click.
                    if (rise) begin
                        press_q <= 1'b1;
                        state_q <= ST_PRESS2;
                    end else if (tmr_eq) begin
                        short_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRESS2: begin
                    // No long detection here: any hold length is a double.
                    if (fall) begin
                        rel_q   <= 1'b1;
                        dbl_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign PRESS_O   = press_q;
    assign RELEASE_O = rel_q;
    assign SHORT_O   = short_q;
    assign LONG_O    = long_q;
    assign DOUBLE_O  = dbl_q;
    assign BUSY_O    = (state_q != ST_IDLE);
`ifdef KEY_EVENT_REPEAT_EN
    assign REPEAT_O  = rep_q;
`else
    assign REPEAT_O  = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: 10 ns clock, LONG=1000, GAP=300,
// REPEAT=200 cycles. Each scenario queues the event vectors it expects, with
// the cycle they must appear in; a negedge monitor pops one entry per cycle
// in which any event output is high.
module tb_key_event_decoder;

    logic CLK_I = 1'b0;
    logic RST_I;
    logic KEY_I;
    logic PRESS_O, RELEASE_O, SHORT_O, LONG_O, DOUBLE_O, REPEAT_O, BUSY_O;

    key_event_decoder #(
        .C_CLK_PRD_NS    (10),
        .C_LONG_PRESS_US (10),
        .C_DOUBLE_GAP_US (3),
        .C_REPEAT_US     (2)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .KEY_I     (KEY_I),
        .PRESS_O   (PRESS_O),
        .RELEASE_O (RELEASE_O),
        .SHORT_O   (SHORT_O),
        .LONG_O    (LONG_O),
        .DOUBLE_O  (DOUBLE_O),
        .REPEAT_O  (REPEAT_O),
        .BUSY_O    (BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    int cyc = 0;
    always @(posedge CLK_I) cyc <= cyc + 1;

    // {PRESS, RELEASE, SHORT, LONG, DOUBLE, REPEAT}
    localparam logic [5:0] E_PR = 6'b100000;
    localparam logic [5:0] E_RL = 6'b010000;
    localparam logic [5:0] E_SH = 6'b001000;
    localparam logic [5:0] E_LG = 6'b000100;
    localparam logic [5:0] E_DB = 6'b000010;
    localparam logic [5:0] E_RP = 6'b000001;

    wire [5:0] ev = {PRESS_O, RELEASE_O, SHORT_O, LONG_O, DOUBLE_O, REPEAT_O};

    typedef struct {
        int         cyc;
        logic [5:0] ev;
    } exp_t;

    exp_t exp_q[$];
    int   errs = 0;
    int   nchk = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [5:0] e);
        exp_t x;
        x.cyc = c;
        x.ev  = e;
        exp_q.push_back(x);
    endtask

    always @(negedge CLK_I) begin : mon
        exp_t e;
        if (!RST_I && ev != 6'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ev", longint'(ev), 0);
            end else begin
                e = exp_q.pop_front();
                chk("ev", longint'(ev), longint'(e.ev));
                chk("ev_cyc", longint'(cyc), longint'(e.cyc));
            end
        end
    end

    // Callers are always #1 after a rising edge, so cyc is settled.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    // Key changes while cyc == c; the DUT samples it at edge c+1, so the
    // resulting pulse is seen with cyc == c+1.
    task automatic drive_at(input int c, input logic v);
        wait_to(c);
        KEY_I = v;
    endtask

    task automatic do_reset(input logic key_in_rst);
        @(posedge CLK_I);
        #3;
        RST_I = 1'b1;
        KEY_I = key_in_rst;
        #1;
        chk("rst_ev_async", longint'(ev), 0);
        chk("rst_busy_async", longint'(BUSY_O), 0);
        exp_q.delete();  // anything in flight is abandoned
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
    endtask

    int b;

    initial begin
        KEY_I = 1'b0;
        RST_I = 1'b0;
        #2;
        RST_I = 1'b1;
        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_ev", longint'(ev), 0);
        chk("rst_busy", longint'(BUSY_O), 0);
        RST_I = 1'b0;

        // Short click: press 400, release, SHORT 300 after RELEASE.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 401, E_RL); push(b + 701, E_SH);
        drive_at(b, 1'b1);
        wait_to(b + 10);  chk("s1_busy_press", longint'(BUSY_O), 1);
        drive_at(b + 400, 1'b0);
        wait_to(b + 500); chk("s1_busy_gap", longint'(BUSY_O), 1);
        wait_to(b + 720); chk("s1_idle", longint'(BUSY_O), 0);
        chk("s1_pending", exp_q.size(), 0);

        // Long press held 1500: LONG at +1000, repeats at +200/+400.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 1001, E_LG);
`ifdef KEY_EVENT_REPEAT_EN
        push(b + 1201, E_RP); push(b + 1401, E_RP);
`endif
        push(b + 1501, E_RL);
        drive_at(b, 1'b1);
        wait_to(b + 1100); chk("s2_busy_hold", longint'(BUSY_O), 1);
        drive_at(b + 1500, 1'b0);
        wait_to(b + 1900); chk("s2_idle", longint'(BUSY_O), 0);
        chk("s2_pending", exp_q.size(), 0);

        // Double click 100/100/100.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 101, E_RL); push(b + 201, E_PR);
        push(b + 301, E_RL | E_DB);
        drive_at(b, 1'b1); drive_at(b + 100, 1'b0);
        drive_at(b + 200, 1'b1); drive_at(b + 300, 1'b0);
        wait_to(b + 700); chk("s3_idle", longint'(BUSY_O), 0);
        chk("s3_pending", exp_q.size(), 0);

        // Second press lands on gap count 299: still a double.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 101, E_RL); push(b + 401, E_PR);
        push(b + 451, E_RL | E_DB);
        drive_at(b, 1'b1); drive_at(b + 100, 1'b0);
        drive_at(b + 400, 1'b1); drive_at(b + 450, 1'b0);
        wait_to(b + 850);
        chk("s4_pending", exp_q.size(), 0);

        // One cycle later: gap expires first, SHORT then a fresh click.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 101, E_RL); push(b + 401, E_SH);
        push(b + 402, E_PR); push(b + 451, E_RL); push(b + 751, E_SH);
        drive_at(b, 1'b1); drive_at(b + 100, 1'b0);
        drive_at(b + 401, 1'b1); drive_at(b + 450, 1'b0);
        wait_to(b + 800);
        chk("s4b_pending", exp_q.size(), 0);

        // Release exactly on long count 999: short path wins.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 1001, E_RL); push(b + 1301, E_SH);
        drive_at(b, 1'b1); drive_at(b + 1000, 1'b0);
        wait_to(b + 1350);
        chk("s5_pending", exp_q.size(), 0);

        // Release one cycle later: LONG then RELEASE, no SHORT.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 1001, E_LG); push(b + 1002, E_RL);
        drive_at(b, 1'b1); drive_at(b + 1001, 1'b0);
        wait_to(b + 1400); chk("s5b_idle", longint'(BUSY_O), 0);
        chk("s5b_pending", exp_q.size(), 0);

        // Key held through reset release: silent until released and pressed.
        do_reset(1'b1);
        b = cyc + 5;
        wait_to(b + 50);
        chk("s6_held_busy", longint'(BUSY_O), 0);
        push(b + 101, E_PR); push(b + 201, E_RL); push(b + 501, E_SH);
        drive_at(b + 50, 1'b0);
        drive_at(b + 100, 1'b1); drive_at(b + 200, 1'b0);
        wait_to(b + 550);
        chk("s6_pending", exp_q.size(), 0);

        // Reset during WAIT_GAP: the pending SHORT must never appear.
        b = cyc + 5;
        push(b + 1, E_PR); push(b + 101, E_RL); push(b + 401, E_SH);
        drive_at(b, 1'b1); drive_at(b + 100, 1'b0);
        wait_to(b + 200); chk("s7_busy_gap", longint'(BUSY_O), 1);
        do_reset(1'b0);
        b = cyc;
        wait_to(b + 500); chk("s7_idle", longint'(BUSY_O), 0);
        chk("s7_pending", exp_q.size(), 0);

        chk("end_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter C_CLK_PRD_NS, default 10: clock period in ns.
REQ-002 SHALL have parameter C_LONG_PRESS_US, default 1000000: hold time at which a press counts as long.
REQ-003 SHALL have parameter C_DOUBLE_GAP_US, default 300000: maximum release-to-press gap for a double click.
REQ-004 SHALL have parameter C_REPEAT_US, default 200000: auto-repeat period after a long press (macro-gated).
REQ-005 SHALL have port CLK_I, input, 1 bit: single clock; everything is synchronous to its rising edge.
REQ-006 SHALL have port RST_I, input, 1 bit: reset, asynchronous assert, active-high.
REQ-007 SHALL have port KEY_I, input, 1 bit: debounced key level from the key debounce stage; 1 = pressed; already synchronous to CLK_I.
REQ-008 SHALL have port PRESS_O, output, 1 bit: one-cycle pulse on each accepted press.
REQ-009 SHALL have port RELEASE_O, output, 1 bit: one-cycle pulse on each accepted release.
REQ-010 SHALL have port SHORT_O, output, 1 bit: one-cycle pulse for a single short click.
REQ-011 SHALL have port LONG_O, output, 1 bit: one-cycle pulse when the long threshold is reached.
REQ-012 SHALL have port DOUBLE_O, output, 1 bit: one-cycle pulse for a double click.
REQ-013 SHALL have port REPEAT_O, output, 1 bit: one-cycle auto-repeat pulse.
REQ-014 SHALL have port BUSY_O, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-015 SHALL convert each time parameter to a cycle count N = US*1000/C_CLK_PRD_NS, clamped to a minimum of 1.
REQ-016 SHALL size the counter as $clog2 of the largest N plus 1; the counter SHALL saturate and never wrap.
REQ-017 SHALL register KEY_I once into key_d; rise = KEY_I & ~key_d, fall = ~KEY_I & key_d.
REQ-018 SHALL assert every event pulse in the cycle after the KEY_I edge or the threshold cycle (latency 1).
REQ-019 SHALL implement five states: IDLE, PRESS1, HOLD, WAIT_GAP, PRESS2.
REQ-020 IDLE: on rise, SHALL pulse PRESS_O, clear the counter and go to PRESS1; a fall in IDLE SHALL be ignored.
REQ-021 PRESS1 on fall: if the counter is below N_LONG-1, SHALL pulse RELEASE_O, clear the counter and go to WAIT_GAP.
REQ-022 PRESS1 while held with the counter equal to N_LONG-1: SHALL pulse LONG_O, clear the counter and go to HOLD.
REQ-023 When a fall and the threshold occur in the same cycle, the fall SHALL win (short click path).
REQ-024 HOLD on fall: SHALL pulse RELEASE_O and go to IDLE.
REQ-025 WAIT_GAP on rise before the counter reaches N_GAP-1: SHALL pulse PRESS_O and go to PRESS2.
REQ-026 WAIT_GAP when the counter reaches N_GAP-1 with no rise: SHALL pulse SHORT_O and go to IDLE.
REQ-027 When a rise and gap expiry coincide, the rise SHALL win.
REQ-028 PRESS2 on fall: SHALL pulse DOUBLE_O and RELEASE_O in the same cycle and go to IDLE, regardless of hold duration; PRESS2 SHALL perform no long detection.
REQ-029 At most one of SHORT_O, LONG_O, DOUBLE_O SHALL be high in any cycle.
REQ-030 Every click sequence SHALL produce exactly one of SHORT_O, LONG_O or DOUBLE_O.

Reset
REQ-031 On RST_I: state = IDLE, counter = 0, all outputs = 0.
REQ-032 On RST_I, key_d SHALL reset to 1, so a key held through reset release produces no PRESS_O until it has been released and pressed again.
REQ-033 Reset mid-sequence SHALL abandon the sequence silently, with no pending event emitted.

Configuration
REQ-034 Macro KEY_EVENT_REPEAT_EN defined: in HOLD, REPEAT_O SHALL pulse each time the counter reaches N_REP-1; the counter then clears.
REQ-035 Macro KEY_EVENT_REPEAT_EN undefined: REPEAT_O SHALL be tied to 0, and no repeat counter logic SHALL be synthesised.

Structure
REQ-036 Package key_event_pkg SHALL hold the state encodings (3-bit) and the us-to-cycles conversion function.
REQ-037 Sub-module key_evt_timer SHALL provide the clear/enable saturating counter with an equal-to-threshold flag; key_event_decoder SHALL instantiate it once.

Verification (C_CLK_PRD_NS=10, LONG=10 us -> 1000 cycles, GAP=3 us -> 300, REPEAT=2 us -> 200)
REQ-038 Press for 400 cycles, then release -> PRESS_O, RELEASE_O, then SHORT_O 300 cycles after release.
REQ-039 Press for 1500 cycles -> LONG_O 1000 cycles after press; with the macro, REPEAT_O at +200 and +400; RELEASE_O on release; no SHORT_O.
REQ-040 Press 100, release 100, press 100, release -> DOUBLE_O together with the second RELEASE_O; no SHORT_O.
REQ-041 Key high at reset release -> no pulses; after release and press -> PRESS_O once.
REQ-042 Rise exactly on gap cycle 299 -> DOUBLE path taken; fall exactly on long cycle 999 -> SHORT path taken.
REQ-043 RST_I asserted during WAIT_GAP -> outputs 0 immediately; no SHORT_O afterwards.
